// File: rtl/imem_stream_loader_if.sv
// Bundles the byte-stream handshake, the instruction-memory write port and
// the boot status lines of imem_stream_loader.
//   byte_valid/byte_data -> stream byte from the upstream source
//   byte_ready           <- loader can accept a byte
//   mem_we/addr/wdata    <- one-cycle imem word write
//   core_rst             <- active-high reset held on the core until loaded
//   load_done/load_err   <- sticky status flags
//   word_cnt             <- words written so far (ADDR_W+1 bits)
// modport slave is the loader side, modport master the environment side.
interface imem_stream_loader_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_rst;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   word_cnt;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata,
    input  core_rst, load_done, load_err, word_cnt
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata,
    output core_rst, load_done, load_err, word_cnt
  );
endinterface

// File: rtl/imem_stream_loader.sv
// Boot loader: receives a byte stream (4-byte LE word count N, then N LE
// words), writes the words into instruction memory from word 0 and holds
// the core in reset until the image is complete.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : imem_stream_loader_if.slave (stream in, imem write out, status)
module imem_stream_loader #(
  parameter int unsigned MEM_NUM = 4096,
  parameter int unsigned ADDR_W  = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  imem_stream_loader_if.slave  bus
);

  localparam logic [1:0] ST_LEN  = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [ADDR_W-1:0] IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        r_state;
  logic [1:0]        r_lane;
  logic [23:0]       r_asm;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W:0]   r_len;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_core_rst;
  logic              r_done;
  logic              r_err;
  logic [ADDR_W:0]   r_word_cnt;

  logic              w_ready;
  logic              w_accept;
  logic [31:0]       w_word;
  logic              w_len_too_big;
  logic              w_last_word;

  assign w_ready  = !rst && (r_state == ST_LEN || r_state == ST_DATA);
  assign w_accept = bus.byte_valid && w_ready;
  // Only lanes 0..2 are registered; lane 3 is the byte on the bus right now.
  assign w_word        = {bus.byte_data, r_asm};
  assign w_len_too_big = w_word > MEM_NUM;
  assign w_last_word   = (r_word_cnt + CNT_ONE) == r_len;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_LEN;
      r_lane      <= '0;
      r_asm       <= '0;
      r_idx       <= '0;
      r_len       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_core_rst  <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_word_cnt  <= '0;
    end else begin
      r_mem_we <= 1'b0;

      if (w_accept) begin
        r_lane <= r_lane + 2'd1;
        case (r_lane)
          2'd0:    r_asm[7:0]   <= bus.byte_data;
          2'd1:    r_asm[15:8]  <= bus.byte_data;
          2'd2:    r_asm[23:16] <= bus.byte_data;
          default: ;
        endcase
      end

      case (r_state)
        ST_LEN: begin
          if (w_accept && r_lane == 2'd3) begin
            if (w_len_too_big) begin
              r_state <= ST_ERR;
            end else begin
              // N <= MEM_NUM <= 2^ADDR_W, so ADDR_W+1 bits hold it exactly.
              r_len   <= w_word[ADDR_W:0];
              r_state <= (w_word == 32'd0) ? ST_DONE : ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_accept && r_lane == 2'd3) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_idx;
            r_mem_wdata <= w_word;
            r_idx       <= r_idx + IDX_ONE;
            r_word_cnt  <= r_word_cnt + CNT_ONE;
            if (w_last_word) r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done     <= 1'b1;
          r_core_rst <= 1'b0;
        end
        default: begin
          r_err <= 1'b1;
        end
      endcase
    end
  end

  assign bus.byte_ready = w_ready;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.core_rst   = r_core_rst;
  assign bus.load_done  = r_done;
  assign bus.load_err   = r_err;
  assign bus.word_cnt   = r_word_cnt;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Self-checking bench for imem_stream_loader: hand-written latency/reset
// sequences plus a table of stream scenarios with random payloads, checked
// against a reference built directly from the stream format.
module tb_imem_stream_loader;
  localparam int unsigned MEM_NUM = 4096;
  localparam int unsigned ADDR_W  = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_stream_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_stream_loader #(.MEM_NUM(MEM_NUM), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0]        stim[$];
  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];

  always @(negedge clk) begin
    if (bus.mem_we) begin
      wa_q.push_back(bus.mem_addr);
      wd_q.push_back(bus.mem_wdata);
    end
  end

  typedef struct {
    logic [31:0] n;
    int unsigned words;
    int unsigned partial;
    bit          gaps;
    bit          exp_done;
    bit          exp_err;
    int unsigned exp_cnt;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Presents one byte and waits until it is accepted or the bound expires.
  task automatic send_byte(input logic [7:0] b, input bit gaps, input int unsigned bound,
                           output bit ok);
    bit acc;
    int unsigned t;
    ok = 1'b0;
    t  = 0;
    if (gaps) begin
      bus.byte_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (t < bound) begin
      @(negedge clk);
      acc = bus.byte_ready;
      @(posedge clk); #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
      t++;
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit gaps);
    bit ok;
    stim.push_back(b);
    send_byte(b, gaps, 20, ok);
    check("accept", ok, 1);
  endtask

  task automatic push_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] tmp;
      tmp = w >> (8 * i);
      push_byte(tmp[7:0], gaps);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.byte_valid = 1'($urandom_range(0, 1));
    bus.byte_data  = 8'hA5;
    @(posedge clk); #1;
    check("rst_ready", bus.byte_ready, 0);
    @(posedge clk); #1;
    check("rst_core_rst", bus.core_rst, 1);
    check("rst_done", bus.load_done, 0);
    check("rst_err", bus.load_err, 0);
    check("rst_word_cnt", bus.word_cnt, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    rst = 1'b0;
    bus.byte_valid = 1'b0;
    wa_q.delete();
    wd_q.delete();
    stim.delete();
  endtask

  // Expected writes come straight from the stream layout: length, then
  // consecutive 4-byte little-endian words written to addresses 0,1,2,...
  task automatic check_model();
    logic [31:0] n;
    int unsigned nfull, expw, lim;
    n     = {stim[3], stim[2], stim[1], stim[0]};
    nfull = (stim.size() - 4) / 4;
    expw  = (n > MEM_NUM) ? 0 : ((n < nfull) ? int'(n) : nfull);
    check("wr_count", wa_q.size(), expw);
    lim = (wa_q.size() < expw) ? wa_q.size() : expw;
    for (int unsigned i = 0; i < lim; i++) begin
      int unsigned b;
      b = 4 + 4 * i;
      check("wr_addr", wa_q[i], i);
      check("wr_data", wd_q[i], {stim[b+3], stim[b+2], stim[b+1], stim[b]});
    end
  endtask

  initial begin
    bit ok;
    int unsigned nw;

    vecs[0] = '{32'd0,        0,    0, 1'b1, 1'b1, 1'b0, 0};
    vecs[1] = '{32'd1,        1,    0, 1'b1, 1'b1, 1'b0, 1};
    vecs[2] = '{32'd3,        3,    0, 1'b1, 1'b1, 1'b0, 3};
    vecs[3] = '{32'd7,        7,    0, 1'b1, 1'b1, 1'b0, 7};
    vecs[4] = '{32'd4,        2,    2, 1'b1, 1'b0, 1'b0, 2};
    vecs[5] = '{32'd4097,     0,    0, 1'b1, 1'b0, 1'b1, 0};
    vecs[6] = '{32'hFFFFFFFF, 0,    0, 1'b1, 1'b0, 1'b1, 0};
    vecs[7] = '{32'd4096,     4096, 0, 1'b0, 1'b1, 1'b0, 4096};

    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    @(posedge clk); #1;

    // N=2 back-to-back, with exact completion latency.
    do_reset();
    push_word(32'd2, 1'b0);
    push_word(32'h00000093, 1'b0);
    push_word(32'h00100113, 1'b0);
    check("last_we", bus.mem_we, 1);
    check("last_addr", bus.mem_addr, 1);
    check("last_wdata", bus.mem_wdata, 32'h00100113);
    check("done_not_yet", bus.load_done, 0);
    check("core_rst_not_yet", bus.core_rst, 1);
    @(posedge clk); #1;
    check("we_one_cycle", bus.mem_we, 0);
    check("done_after_last", bus.load_done, 1);
    check("core_rel_after_last", bus.core_rst, 0);
    check("cnt_two", bus.word_cnt, 2);
    check("ready_done", bus.byte_ready, 0);
    check_model();

    // N=0: completion one cycle after the 4th length byte.
    do_reset();
    push_word(32'd0, 1'b0);
    check("n0_done_not_yet", bus.load_done, 0);
    @(posedge clk); #1;
    check("n0_done", bus.load_done, 1);
    check("n0_core_rst", bus.core_rst, 0);
    check("n0_ready", bus.byte_ready, 0);
    check_model();

    // Reset after 6 of 8 data bytes, then a fresh single-word load.
    do_reset();
    push_word(32'd2, 1'b1);
    push_word(32'h11223344, 1'b1);
    push_byte(8'h55, 1'b1);
    push_byte(8'h66, 1'b1);
    check("mid_writes", wa_q.size(), 1);
    rst = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hAA;
    @(posedge clk); #1;
    check("mid_core_rst", bus.core_rst, 1);
    check("mid_word_cnt", bus.word_cnt, 0);
    check("mid_mem_we", bus.mem_we, 0);
    check("mid_ready", bus.byte_ready, 0);
    rst = 1'b0;
    bus.byte_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_no_extra_write", wa_q.size(), 1);
    wa_q.delete();
    wd_q.delete();
    stim.delete();
    push_word(32'd1, 1'b1);
    push_word(32'hDEADBEEF, 1'b1);
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("restream_done", bus.load_done, 1);
    check_model();

    // Table of stream scenarios with random payload words.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      push_word(vecs[v].n, vecs[v].gaps);
      nw = vecs[v].words;
      for (int unsigned w = 0; w < nw; w++) push_word($urandom, vecs[v].gaps);
      for (int unsigned p = 0; p < vecs[v].partial; p++)
        push_byte(8'($urandom), vecs[v].gaps);
      repeat (3) begin
        @(posedge clk); #1;
      end
      check("tbl_done", bus.load_done, vecs[v].exp_done);
      check("tbl_err", bus.load_err, vecs[v].exp_err);
      check("tbl_core_rst", bus.core_rst, !vecs[v].exp_done);
      check("tbl_word_cnt", bus.word_cnt, vecs[v].exp_cnt);
      check("tbl_ready", bus.byte_ready, !(vecs[v].exp_done || vecs[v].exp_err));
      if (vecs[v].exp_done || vecs[v].exp_err) begin
        send_byte(8'h13, 1'b0, 4, ok);
        check("tbl_extra_rejected", ok, 0);
        send_byte(8'h37, 1'b0, 4, ok);
        check("tbl_extra_rejected2", ok, 0);
        @(posedge clk); #1;
        check("tbl_done_sticky", bus.load_done, vecs[v].exp_done);
        check("tbl_err_sticky", bus.load_err, vecs[v].exp_err);
      end
      check_model();
      if (v == 7 && wa_q.size() == MEM_NUM)
        check("tbl_last_addr", wa_q[MEM_NUM-1], 12'hFFF);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Upstream boot stage for the SoC. Receives a byte stream over a valid/ready handshake and packs the bytes little-endian into 32-bit words.
- Writes those words into instruction memory, starting at word 0.
- Holds the core in reset until the load completes, replacing backdoor memory preload with a synthesizable path.
- Stream format: 4-byte little-endian word count N, followed by N words of 4 bytes each, little-endian.

Parameters:
- MEM_NUM, 4096, instruction memory depth in 32-bit words.
- ADDR_W, 12, word-address width; must satisfy 2^ADDR_W >= MEM_NUM.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, synchronous, active-high.
- byte_valid  in  1  stream byte present.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader can accept a byte.
- mem_we  out  1  imem word write strobe, one cycle per word.
- mem_addr  out  ADDR_W  imem word index.
- mem_wdata  out  32  imem write data.
- core_rst  out  1  active-high reset to the core.
- load_done  out  1  image loaded; sticky until rst.
- load_err  out  1  length error; sticky until rst.
- word_cnt  out  ADDR_W+1  words written so far.

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous, active-high, sampled on the rising edge.
- Reset values: state=LEN, lane=0, word index=0, length=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rst=1, load_done=0, load_err=0, word_cnt=0.
- byte_ready: combinational, =1 only when rst=0 and state is LEN or DATA; 0 in DONE and ERR.
- Handshake: a byte is accepted on a rising edge with byte_valid=1 and byte_ready=1.
  - byte_data must be stable while byte_valid=1 and byte_ready=0.
  - Back-to-back accepts every cycle are allowed.
- Lane counter: 2 bits, advances on each accept and wraps 3->0. Accepted byte k lands in bits [8k+7:8k] of the assembly register.
- LEN state:
  - On the 4th accepted byte, length N = {b3,b2,b1,b0}.
  - N > MEM_NUM -> ERR.
  - N == 0 -> DONE.
  - Otherwise -> DATA.
- DATA state, on the 4th byte of each word:
  - mem_we<=1, mem_addr<=word index, mem_wdata<=full assembled word (including the byte just accepted).
  - word index++, word_cnt++.
  - mem_we is high for exactly 1 cycle; writes are therefore at most one every 4 cycles.
  - If this is word N-1, state<=DONE on the same edge.
- DONE state:
  - At the first edge in DONE: load_done<=1, core_rst<=0. Both hold until rst.
  - Latency: load_done rises and core_rst falls exactly 1 cycle after the final mem_we pulse, or 1 cycle after the 4th length byte when N=0.
  - Further byte_valid is ignored; mem_we stays 0.
- ERR state: load_err<=1 on the edge after entry; core_rst stays 1, mem_we stays 0, byte_ready=0. Only rst exits.
- Partial word: bytes pending when the stream stalls stay held indefinitely; no timeout.
- Reset mid-load: all state returns to reset values on the next edge. Words already written are not cleared; mem_we is forced 0 in that cycle.
- Boundary conditions:
  - N == MEM_NUM is legal; the last write goes to address MEM_NUM-1.
  - N == MEM_NUM+1 -> ERR.
- Width rules: word_cnt is ADDR_W+1 bits so it can hold MEM_NUM; the word index never exceeds MEM_NUM-1 on mem_addr.

Test Plan:
- Reset then stream N=2, words 0x00000093, 0x00100113, one byte per cycle -> mem_we pulses at addr 0 (0x00000093) and addr 1 (0x00100113); load_done=1 and core_rst=0 one cycle after the 2nd pulse; word_cnt=2.
- Same stream with byte_valid toggled 1/0 randomly, plus byte_valid held high during rst -> identical writes; no byte accepted while rst=1 or in DONE; mem_addr never skips.
- N=0 (bytes 00 00 00 00) -> no mem_we; load_done=1 and core_rst=0 one cycle after the 4th byte; byte_ready=0 afterwards.
- N=MEM_NUM+1 (0x00001001 with default parameters) -> load_err=1, core_rst stays 1, byte_ready=0, no mem_we; N=MEM_NUM with 4096 words -> last write at addr 0xFFF, load_done=1.
- Assert rst after 6 of 8 data bytes (N=2) -> next cycle core_rst=1, word_cnt=0, lane=0; re-stream N=1, word 0xDEADBEEF -> single write at addr 0 with 0xDEADBEEF.
- Extra bytes sent after DONE -> byte_ready=0, no writes, load_done remains 1.
